// File: rtl/xmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// xmem_bus_ctrl
// Sequencer between the gus16 core and the multiplexed 8-bit external SRAM bus.
// One 16-bit word request becomes: optional address-latch phases (xlal, xlah)
// followed by byte phases xbh=0 (low byte) and/or xbh=1 (high byte).
// External byte address = {latched addr[14:0], xbh}.
// Every pad strobe and data/enable output comes straight from a flop.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req/we/addr/     request; fields captured when req=1 and the FSM is idle
//   wdata/be
//   busy, ack        busy from the cycle after accept through ack; ack = 1-cycle done
//   rdata            read word, updated only on a read ack
//   bus_out/bus_oe   pad data out and output enable (all 8 enable bits equal)
//   bus_in           pad data in
//   xlal, xlah       address latch strobes (active high)
//   xbh              byte select
//   xoeb, xweb       SRAM output enable / write enable (active low)
// -----------------------------------------------------------------------------
module xmem_bus_ctrl #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_CACHE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_in,
  output logic        xlal,
  output logic        xlah,
  output logic        xbh,
  output logic        xoeb,
  output logic        xweb
);

  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LAL, S_LAH, S_RD, S_WSET, S_WSTB, S_WHLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        bh_q, bh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] rdata_q;
  logic        cvalid_q;
  logic [15:0] caddr_q;

  logic [7:0]  bus_out_q, bus_out_d;
  logic [7:0]  bus_oe_q, bus_oe_d;
  logic        xlal_q, xlal_d, xlah_q, xlah_d, xbh_q, xbh_d;
  logic        xoeb_q, xoeb_d, xweb_q, xweb_d;
  logic        ack_q, ack_d, busy_q, busy_d;

  // While idle the live inputs describe the operation being accepted; once
  // accepted the captured copies are used, so later input changes are ignored.
  logic        idle, hit, last_wait;
  logic        op_we, fb_bh;
  logic [1:0]  op_be;
  logic [15:0] op_addr, op_wdata;
  state_t      fb_state;

  assign idle      = (state_q == S_IDLE);
  assign op_we     = idle ? we    : we_q;
  assign op_be     = idle ? be    : be_q;
  assign op_addr   = idle ? addr  : addr_q;
  assign op_wdata  = idle ? wdata : wdata_q;
  assign hit       = (ADDR_CACHE != 0) && cvalid_q && (addr == caddr_q);
  assign last_wait = (cnt_q == WAIT_C);
  // First byte phase: reads always start at the low byte; writes start at the
  // lowest enabled byte (be is known non-zero whenever this is used).
  assign fb_state  = op_we ? S_WSET : S_RD;
  assign fb_bh     = op_we & ~op_be[0];

  // State register (control and pad flops, async reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bh_q      <= 1'b0;
      cnt_q     <= '0;
      cvalid_q  <= 1'b0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      bus_oe_q  <= '0;
      xlal_q    <= 1'b0;
      xlah_q    <= 1'b0;
      xbh_q     <= 1'b0;
      xoeb_q    <= 1'b1;
      xweb_q    <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bh_q      <= bh_d;
      cnt_q     <= cnt_d;
      if (state_q == S_LAH) cvalid_q <= 1'b1;
      if (state_d == S_DONE && !op_we) rdata_q <= shadow_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      xlal_q    <= xlal_d;
      xlah_q    <= xlah_d;
      xbh_q     <= xbh_d;
      xoeb_q    <= xoeb_d;
      xweb_q    <= xweb_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  // Data capture (no reset needed: only read after being loaded)
  always_ff @(posedge clk) begin
    if (idle && req) begin
      we_q    <= we;
      be_q    <= be;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
    if (state_q == S_LAH) caddr_q <= addr_q;
    shadow_q <= shadow_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    bh_d     = bh_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (state_q == S_RD && last_wait) begin
      if (bh_q) shadow_d[15:8] = bus_in;
      else      shadow_d[7:0]  = bus_in;
    end
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (we && be == 2'b00) begin
            state_d = S_DONE;
          end else if (hit) begin
            state_d = fb_state;
            bh_d    = fb_bh;
            cnt_d   = '0;
          end else begin
            state_d = S_LAL;
          end
        end
      end
      S_LAL: state_d = S_LAH;
      S_LAH: begin
        state_d = fb_state;
        bh_d    = fb_bh;
        cnt_d   = '0;
      end
      S_RD: begin
        if (!last_wait) begin
          cnt_d = cnt_q + 3'd1;
        end else if (!bh_q) begin
          bh_d  = 1'b1;
          cnt_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WSET: begin
        state_d = S_WSTB;
        cnt_d   = '0;
      end
      S_WSTB: begin
        if (last_wait) state_d = S_WHLD;
        else           cnt_d   = cnt_q + 3'd1;
      end
      S_WHLD: begin
        if (!bh_q && be_q[1]) begin
          state_d = S_WSET;
          bh_d    = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the pads launch from flops
  always_comb begin
    bus_out_d = '0;
    bus_oe_d  = '0;
    xlal_d    = 1'b0;
    xlah_d    = 1'b0;
    xbh_d     = 1'b0;
    xoeb_d    = 1'b1;
    xweb_d    = 1'b1;
    ack_d     = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_LAL: begin
        bus_out_d = op_addr[7:0];
        bus_oe_d  = 8'hFF;
        xlal_d    = 1'b1;
      end
      S_LAH: begin
        bus_out_d = op_addr[15:8];
        bus_oe_d  = 8'hFF;
        xlah_d    = 1'b1;
      end
      S_RD: begin
        xbh_d  = bh_d;
        xoeb_d = 1'b0;
      end
      S_WSET, S_WSTB, S_WHLD: begin
        // xbh and data settle in SETUP and stay put until HOLD ends
        bus_out_d = bh_d ? op_wdata[15:8] : op_wdata[7:0];
        bus_oe_d  = 8'hFF;
        xbh_d     = bh_d;
        xweb_d    = (state_d != S_WSTB);
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign xlal    = xlal_q;
  assign xlah    = xlah_q;
  assign xbh     = xbh_q;
  assign xoeb    = xoeb_q;
  assign xweb    = xweb_q;

endmodule
